// File: rtl/ifetch_buf.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module   : ifetch_buf                                                     |
// | Purpose  : IRAM prefetch queue feeding the instruction register; credit-  |
// |            based request issue with flush/discard of stale responses.     |
// | Options  : IFETCH_PARITY_CHECK_EN enables sticky odd-parity check on pop. |
// | Revision : 1.0                                                            |
// +---------------------------------------------------------------------------+
module ifetch_buf #(
  parameter int DEPTH = 2,
  parameter int AW    = 14
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic [AW-1:0] flush_pc,
  input  logic          state_fetch,
  output logic          iram_req,
  output logic [AW-1:0] iram_addr,
  input  logic          iram_gnt,
  input  logic          iram_rvalid,
  input  logic [48:0]   iram_rdata,
  output logic [48:0]   i,
  output logic          i_valid,
  output logic          ipar_err
);

  localparam int c_cnt_w = $clog2(DEPTH + 1);
  localparam int c_ptr_w = $clog2(DEPTH);

  logic [AW-1:0]      r_npc;
  logic [48:0]        r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_cnt_w-1:0] r_count;
  logic [c_cnt_w-1:0] r_outstanding;
  logic [c_cnt_w-1:0] r_discard;

  logic w_grant;
  logic w_stale;
  logic w_live_ret;
  logic w_push;
  logic w_pop;

  // Credits cover both in-flight and buffered words, so a push never finds the FIFO full.
  assign iram_req   = reset & ~flush & ((int'(r_outstanding) + int'(r_count)) < DEPTH);
  assign iram_addr  = r_npc;
  assign i_valid    = (r_count != '0);
  assign i          = i_valid ? r_mem[r_rd_ptr] : '0;

  assign w_grant    = iram_req & iram_gnt;
  assign w_stale    = iram_rvalid & (r_discard != '0);
  assign w_live_ret = iram_rvalid & (r_discard == '0);
  assign w_push     = w_live_ret & ~flush;
  assign w_pop      = state_fetch & i_valid & ~flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_npc         <= '0;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_count       <= '0;
      r_outstanding <= '0;
      r_discard     <= '0;
    end else if (flush) begin
      // Everything still in flight becomes stale; the word arriving now is dropped here.
      r_npc         <= flush_pc;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_count       <= '0;
      r_outstanding <= '0;
      r_discard     <= r_discard + r_outstanding - c_cnt_w'(iram_rvalid);
    end else begin
      if (w_grant) r_npc    <= r_npc + AW'(1);
      if (w_push)  r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
      if (w_pop)   r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      r_count       <= r_count + c_cnt_w'(w_push) - c_cnt_w'(w_pop);
      r_outstanding <= r_outstanding + c_cnt_w'(w_grant) - c_cnt_w'(w_live_ret);
      r_discard     <= r_discard - c_cnt_w'(w_stale);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= iram_rdata;
  end

`ifdef IFETCH_PARITY_CHECK_EN
  logic r_ipar_err;
  logic w_par_bad;

  // Bit 48 must equal XNOR-reduce of the payload (odd parity over all 49 bits).
  assign w_par_bad = w_pop & (i[48] != ~^i[47:0]);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ipar_err <= 1'b0;
    end else if (flush) begin
      r_ipar_err <= 1'b0;
    end else if (w_par_bad) begin
      r_ipar_err <= 1'b1;
    end
  end

  assign ipar_err = r_ipar_err;
`else
  assign ipar_err = 1'b0;
`endif

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (reset && w_push && !w_pop) begin
      assert (int'(r_count) < DEPTH) else $error("ifetch_buf: push into full queue");
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_ifetch_buf.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module   : tb_ifetch_buf                                                  |
// | Purpose  : Directed self-checking bench for ifetch_buf with an IRAM model |
// |            of programmable latency; honours IFETCH_PARITY_CHECK_EN.       |
// | Revision : 1.0                                                            |
// +---------------------------------------------------------------------------+
module tb_ifetch_buf;

  localparam int DEPTH = 2;
  localparam int AW    = 14;
`ifdef IFETCH_PARITY_CHECK_EN
  localparam logic c_par = 1'b1;
`else
  localparam logic c_par = 1'b0;
`endif

  logic          clk;
  logic          reset;
  logic          flush;
  logic [AW-1:0] flush_pc;
  logic          state_fetch;
  logic          iram_req;
  logic [AW-1:0] iram_addr;
  logic          iram_gnt;
  logic          iram_rvalid;
  logic [48:0]   iram_rdata;
  logic [48:0]   i;
  logic          i_valid;
  logic          ipar_err;

  ifetch_buf #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset), .flush(flush), .flush_pc(flush_pc),
    .state_fetch(state_fetch), .iram_req(iram_req), .iram_addr(iram_addr),
    .iram_gnt(iram_gnt), .iram_rvalid(iram_rvalid), .iram_rdata(iram_rdata),
    .i(i), .i_valid(i_valid), .ipar_err(ipar_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int            n_checks;
  int            n_err;
  int            cyc;
  int            lat;
  int            n_gr;
  int            n_pop;
  logic          bad_en;
  logic [AW-1:0] bad_addr;
  logic [AW-1:0] exp_req;
  logic [AW-1:0] exp_pop;
  logic [AW-1:0] pq_addr [$];
  int            pq_due  [$];

  // IRAM content: good odd parity unless the address is marked bad.
  function automatic logic [48:0] word_of(input logic [AW-1:0] a);
    logic [47:0] lo;
    if (bad_en && a == bad_addr) return {1'b1, 48'h1};
    lo = {20'hABCDE, 14'h0, a};
    return {~^lo, lo};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called just after a falling edge: drive this cycle's inputs and IRAM response.
  task automatic set_in(input logic fl, input logic [AW-1:0] fpc, input logic sf);
    flush       = fl;
    flush_pc    = fpc;
    state_fetch = sf;
    if (pq_addr.size() != 0 && pq_due[0] <= cyc) begin
      iram_rvalid = 1'b1;
      iram_rdata  = word_of(pq_addr[0]);
    end else begin
      iram_rvalid = 1'b0;
      iram_rdata  = '0;
    end
    #1;
  endtask

  task automatic step();
    logic          g;
    logic          rv;
    logic [AW-1:0] a;
    g  = iram_req & iram_gnt;
    a  = iram_addr;
    rv = iram_rvalid;
    @(posedge clk);
    if (rv) begin
      pq_addr.delete(0);
      pq_due.delete(0);
    end
    if (g) begin
      pq_addr.push_back(a);
      pq_due.push_back(cyc + lat);
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    reset       = 1'b0;
    flush       = 1'b0;
    flush_pc    = '0;
    state_fetch = 1'b0;
    iram_gnt    = 1'b0;
    iram_rvalid = 1'b0;
    iram_rdata  = '0;
    pq_addr.delete();
    pq_due.delete();
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_req",  iram_req,  0);
    chk("rst_addr", iram_addr, 0);
    chk("rst_iv",   i_valid,   0);
    chk("rst_i",    i,         0);
    chk("rst_par",  ipar_err,  0);
    reset = 1'b1;
    cyc   = 0;
  endtask

  // Free-running fetch: grants must walk addresses in order, pops must follow them.
  task automatic stream(input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      set_in(1'b0, '0, 1'b1);
      if (iram_req) begin
        chk({tag, "_addr"}, iram_addr, exp_req);
        exp_req++;
        n_gr++;
      end
      if (i_valid) begin
        chk({tag, "_i"}, i, word_of(exp_pop));
        exp_pop++;
        n_pop++;
      end
      step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    n_checks = 0; n_err = 0; cyc = 0; lat = 1;
    bad_en = 1'b0; bad_addr = '0;
    @(negedge clk);

    // Streaming at latency 1 with continuous consumption
    do_reset();
    lat = 1; iram_gnt = 1'b1;
    exp_req = '0; exp_pop = '0; n_gr = 0; n_pop = 0;
    stream(30, "t1");
    chk("t1_pops_ge15", (n_pop >= 15), 1);

    // Stalled consumer, latency 2: credits cap requests at DEPTH
    do_reset();
    lat = 2; iram_gnt = 1'b1;
    set_in(0, '0, 0); chk("t2_c0_req", iram_req, 1); chk("t2_c0_addr", iram_addr, 0); step();
    set_in(0, '0, 0); chk("t2_c1_req", iram_req, 1); chk("t2_c1_addr", iram_addr, 1); step();
    set_in(0, '0, 0); chk("t2_c2_req", iram_req, 0); chk("t2_c2_iv", i_valid, 0);    step();
    set_in(0, '0, 0); chk("t2_c3_iv", i_valid, 1);   chk("t2_c3_i", i, word_of(0));
    chk("t2_c3_req", iram_req, 0); step();
    set_in(0, '0, 1); chk("t2_c4_req", iram_req, 0); chk("t2_c4_i", i, word_of(0));   step();
    set_in(0, '0, 0); chk("t2_c5_i", i, word_of(1)); chk("t2_c5_req", iram_req, 1);
    chk("t2_c5_addr", iram_addr, 2); step();
    set_in(0, '0, 0); chk("t2_c6_req", iram_req, 0); step();
    set_in(0, '0, 0); step();
    set_in(0, '0, 0); chk("t2_c8_iv", i_valid, 1); chk("t2_c8_i", i, word_of(1));

    // Mid-operation reset with a full queue, then flush with words in flight
    do_reset();
    lat = 2; iram_gnt = 1'b1;
    set_in(1, 14'h0005, 0); chk("t3_flush_req", iram_req, 0); step();
    set_in(0, '0, 0); chk("t3_addr5", iram_addr, 14'h0005); chk("t3_req5", iram_req, 1); step();
    set_in(0, '0, 0); chk("t3_addr6", iram_addr, 14'h0006); step();
    set_in(1, 14'h0100, 0); chk("t3_rv_in_f", iram_rvalid, 1); chk("t3_f_req", iram_req, 0); step();
    set_in(0, '0, 0); chk("t3_addr100", iram_addr, 14'h0100); chk("t3_req100", iram_req, 1);
    chk("t3_iv_a", i_valid, 0); step();
    set_in(0, '0, 0); chk("t3_addr101", iram_addr, 14'h0101); chk("t3_iv_b", i_valid, 0); step();
    set_in(0, '0, 0); chk("t3_iv_c", i_valid, 0); step();
    // Flush coincides with rvalid and state_fetch
    set_in(1, 14'h0200, 1); chk("t4_iv", i_valid, 1); chk("t4_i", i, word_of(14'h0100));
    chk("t4_rv", iram_rvalid, 1); chk("t4_req", iram_req, 0); step();
    set_in(0, '0, 0); chk("t4_iv_after", i_valid, 0); chk("t4_addr200", iram_addr, 14'h0200); step();
    set_in(0, '0, 0); chk("t4_addr201", iram_addr, 14'h0201); step();
    set_in(0, '0, 0); chk("t4_iv_wait", i_valid, 0); step();
    set_in(0, '0, 0); chk("t4_iv_new", i_valid, 1); chk("t4_i_new", i, word_of(14'h0200)); step();
    set_in(0, '0, 0); chk("t4_i_hold", i, word_of(14'h0200));

    // Address wrap at the top of IRAM
    do_reset();
    lat = 1; iram_gnt = 1'b1;
    set_in(1, 14'h3FFE, 1); chk("t5_f_req", iram_req, 0); step();
    exp_req = 14'h3FFE; exp_pop = 14'h3FFE; n_gr = 0; n_pop = 0;
    stream(12, "t5");
    chk("t5_grants_ge4", (n_gr >= 4), 1);
    chk("t5_pops_ge4",   (n_pop >= 4), 1);

    // Parity: bad word at address 0 popped, then held until flush
    do_reset();
    bad_en = 1'b1; bad_addr = '0; lat = 1; iram_gnt = 1'b1;
    set_in(0, '0, 0); step();
    set_in(0, '0, 0); step();
    set_in(0, '0, 0); step();
    set_in(0, '0, 1); chk("t6_i_bad", i, {1'b1, 48'h1}); chk("t6_par_pre", ipar_err, 0); step();
    set_in(0, '0, 0); chk("t6_par_set", ipar_err, c_par); chk("t6_i_next", i, word_of(1)); step();
    set_in(1, '0, 0); chk("t6_par_hold", ipar_err, c_par); step();
    set_in(0, '0, 0); chk("t6_par_clr", ipar_err, 0); step();
    set_in(0, '0, 0); step();
    // Bad head discarded by flush+state_fetch is never checked
    set_in(1, 14'h0010, 1); chk("t6_i_bad2", i, {1'b1, 48'h1}); step();
    set_in(0, '0, 0); chk("t6_par_noflag", ipar_err, 0); chk("t6_iv_flushed", i_valid, 0); step();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
